// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter: shares the CSR unit's single read/write port between the
// pipeline's CSR path (default owner, zero-latency) and a host/debug request
// channel. A host request waits for an idle pipeline cycle, or is forced in
// after STARVE_LIMIT consecutive blocked cycles by stalling the pipeline once.
// Optional build macro: CSR_ARB_STALL_COUNT_EN adds the stall_count output.
module csr_access_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    // pipeline side
    input  logic        pipe_req,
    input  logic        pipe_we,
    input  logic [11:0] pipe_num,
    input  logic [1:0]  pipe_code,
    input  logic [31:0] pipe_wdata,
    output logic [31:0] pipe_rdata,
    output logic        pipe_stall,
    // host request / response channel
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic        host_req_we,
    input  logic [11:0] host_req_num,
    input  logic [31:0] host_req_wdata,
    output logic        host_resp_valid,
    output logic [31:0] host_resp_data,
    input  logic        host_resp_ready,
`ifdef CSR_ARB_STALL_COUNT_EN
    output logic [31:0] stall_count,
`endif
    // CSR unit port
    output logic        csr_we,
    output logic [11:0] csr_num,
    output logic [1:0]  csr_code,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata
);

    localparam logic [CNT_WIDTH-1:0] LimitVal = CNT_WIDTH'(STARVE_LIMIT);

    localparam logic [1:0] CodeWrite    = 2'b00;
    localparam logic [1:0] CodeReadOnly = 2'b11;

    typedef enum logic [1:0] {
        stIdle,
        stWait,
        stAccess,
        stResp
    } hostStateT;

    hostStateT            state;
    hostStateT            nextState;
    logic [CNT_WIDTH-1:0] starveCnt;
    logic                 latchWe;
    logic [11:0]          latchNum;
    logic [31:0]          latchWdata;
    logic [31:0]          respData;

    // Host FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= stIdle;
        end else begin
            state <= nextState;
        end
    end

    // Host request latch, starvation counter and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            starveCnt  <= '0;
            latchWe    <= 1'b0;
            latchNum   <= '0;
            latchWdata <= '0;
            respData   <= '0;
        end else begin
            case (state)
                stIdle: begin
                    if (host_req_valid) begin
                        latchWe    <= host_req_we;
                        latchNum   <= host_req_num;
                        latchWdata <= host_req_wdata;
                        starveCnt  <= '0;
                    end
                end
                stWait: begin
                    // Saturates: the count stops once it reaches the limit.
                    if (pipe_req && (starveCnt != LimitVal)) begin
                        starveCnt <= starveCnt + 1'b1;
                    end
                end
                stAccess: begin
                    // Captured before the write edge, so a host write
                    // reports the pre-write CSR value.
                    respData <= csr_rdata;
                end
                default: ;
            endcase
        end
    end

    // Host FSM next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            stIdle: begin
                if (host_req_valid) begin
                    nextState = stWait;
                end
            end
            stWait: begin
                // The registered count is compared, so a fully blocked host
                // spends STARVE_LIMIT+1 cycles in WAIT before being forced in.
                if ((starveCnt == LimitVal) || !pipe_req) begin
                    nextState = stAccess;
                end
            end
            stAccess: begin
                nextState = stResp;
            end
            stResp: begin
                if (host_resp_ready) begin
                    nextState = stIdle;
                end
            end
            default: begin
                nextState = stIdle;
            end
        endcase
    end

    // Port mux: host owns the CSR port only during ACCESS.
    always_comb begin
        host_req_ready  = (state == stIdle);
        host_resp_valid = (state == stResp);
        host_resp_data  = respData;

        csr_we     = pipe_req & pipe_we;
        csr_num    = pipe_num;
        csr_code   = pipe_req ? pipe_code : CodeReadOnly;
        csr_wdata  = pipe_wdata;
        pipe_rdata = csr_rdata;
        pipe_stall = 1'b0;

        if (state == stAccess) begin
            csr_we     = latchWe;
            csr_num    = latchNum;
            csr_code   = latchWe ? CodeWrite : CodeReadOnly;
            csr_wdata  = latchWdata;
            pipe_rdata = '0;
            pipe_stall = pipe_req;
        end
    end

`ifdef CSR_ARB_STALL_COUNT_EN
    // Free-running count of pipeline stall cycles, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (pipe_stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Testbench for csr_access_arbiter: behavioural CSR unit, a vector table for
// the pipeline-only port mux, and hand sequences for host transactions with
// a response scoreboard.
module tb_csr_access_arbiter;

    localparam int unsigned LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_req;
    logic        pipe_we;
    logic [11:0] pipe_num;
    logic [1:0]  pipe_code;
    logic [31:0] pipe_wdata;
    logic [31:0] pipe_rdata;
    logic        pipe_stall;
    logic        host_req_valid;
    logic        host_req_ready;
    logic        host_req_we;
    logic [11:0] host_req_num;
    logic [31:0] host_req_wdata;
    logic        host_resp_valid;
    logic [31:0] host_resp_data;
    logic        host_resp_ready;
    logic        csr_we;
    logic [11:0] csr_num;
    logic [1:0]  csr_code;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
`ifdef CSR_ARB_STALL_COUNT_EN
    logic [31:0] stall_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] respQ[$];

    logic        memClr;
    logic [31:0] csrMem [4096];

    // Clock generation.
    always #5 clk = ~clk;

    csr_access_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_req(pipe_req),
        .pipe_we(pipe_we),
        .pipe_num(pipe_num),
        .pipe_code(pipe_code),
        .pipe_wdata(pipe_wdata),
        .pipe_rdata(pipe_rdata),
        .pipe_stall(pipe_stall),
        .host_req_valid(host_req_valid),
        .host_req_ready(host_req_ready),
        .host_req_we(host_req_we),
        .host_req_num(host_req_num),
        .host_req_wdata(host_req_wdata),
        .host_resp_valid(host_resp_valid),
        .host_resp_data(host_resp_data),
        .host_resp_ready(host_resp_ready),
`ifdef CSR_ARB_STALL_COUNT_EN
        .stall_count(stall_count),
`endif
        .csr_we(csr_we),
        .csr_num(csr_num),
        .csr_code(csr_code),
        .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata)
    );

    // Behavioural CSR unit: combinational read, write/set/clear at the edge.
    assign csr_rdata = csrMem[csr_num];
    always @(posedge clk) begin
        if (memClr) begin
            for (int i = 0; i < 4096; i++) csrMem[i] <= '0;
        end else if (csr_we) begin
            case (csr_code)
                2'b00:   csrMem[csr_num] <= csr_wdata;
                2'b01:   csrMem[csr_num] <= csrMem[csr_num] | csr_wdata;
                2'b10:   csrMem[csr_num] <= csrMem[csr_num] & ~csr_wdata;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed host response is matched against the queue.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && host_resp_valid && host_resp_ready) begin
            if (respQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got %0h want none", host_resp_data);
            end else begin
                e = respQ.pop_front();
                check("host_resp_data", host_resp_data, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hostDrive(input logic we, input logic [11:0] num, input logic [31:0] wd);
        host_req_valid = 1'b1;
        host_req_we    = we;
        host_req_num   = num;
        host_req_wdata = wd;
    endtask

    task automatic waitResp(input int bound, input string name);
        int n = 0;
        while (!host_resp_valid && n < bound) begin
            tick();
            n++;
        end
        check({name, "_resp_valid"}, 32'(host_resp_valid), 32'd1);
    endtask

    // Full host transaction from an IDLE cycle; returns in the cycle after RESP.
    task automatic hostTxn(input logic we, input logic [11:0] num, input logic [31:0] wd,
                           input logic [31:0] expData, input string name);
        hostDrive(we, num, wd);
        respQ.push_back(expData);
        tick();
        host_req_valid = 1'b0;
        waitResp(LIMIT + 4, name);
        tick();
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [11:0] num;
        logic [1:0]  code;
        logic [31:0] wdata;
        logic        expWe;
        logic [1:0]  expCode;
        logic [31:0] expRdata;
    } vecT;

    vecT vecs[10];

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // pipeline-only mux vectors; CSR memory starts cleared
        vecs[0] = '{1'b1, 1'b1, 12'h300, 2'b00, 32'h0000_1800, 1'b1, 2'b00, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 12'h300, 2'b11, 32'h0000_0000, 1'b0, 2'b11, 32'h0000_1800};
        vecs[2] = '{1'b1, 1'b1, 12'h340, 2'b01, 32'h0000_000F, 1'b1, 2'b01, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b1, 12'h340, 2'b01, 32'h0000_00F0, 1'b1, 2'b01, 32'h0000_000F};
        vecs[4] = '{1'b1, 1'b1, 12'h340, 2'b10, 32'h0000_000F, 1'b1, 2'b10, 32'h0000_00FF};
        vecs[5] = '{1'b1, 1'b0, 12'h340, 2'b11, 32'h0000_0000, 1'b0, 2'b11, 32'h0000_00F0};
        vecs[6] = '{1'b0, 1'b1, 12'h340, 2'b01, 32'h0000_1234, 1'b0, 2'b11, 32'h0000_00F0};
        vecs[7] = '{1'b1, 1'b0, 12'h340, 2'b01, 32'h0000_AAAA, 1'b0, 2'b01, 32'h0000_00F0};
        vecs[8] = '{1'b1, 1'b1, 12'h305, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 32'h0000_0000};
        vecs[9] = '{1'b1, 1'b1, 12'h340, 2'b00, 32'h0000_0000, 1'b1, 2'b00, 32'h0000_00F0};

        rst = 1'b1; memClr = 1'b1;
        pipe_req = 1'b0; pipe_we = 1'b0; pipe_num = '0; pipe_code = 2'b11; pipe_wdata = '0;
        host_req_valid = 1'b0; host_req_we = 1'b0; host_req_num = '0; host_req_wdata = '0;
        host_resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; memClr = 1'b0;
        #2;
        check("rst_req_ready", 32'(host_req_ready), 32'd1);
        check("rst_resp_valid", 32'(host_resp_valid), 32'd0);
        check("rst_resp_data", host_resp_data, 32'd0);
        check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        check("rst_csr_we", 32'(csr_we), 32'd0);

        // Pipeline-only port mux.
        for (int i = 0; i < 10; i++) begin
            tick();
            pipe_req = vecs[i].req; pipe_we = vecs[i].we; pipe_num = vecs[i].num;
            pipe_code = vecs[i].code; pipe_wdata = vecs[i].wdata;
            #2;
            check("vec_csr_we", 32'(csr_we), 32'(vecs[i].expWe));
            check("vec_csr_code", 32'(csr_code), 32'(vecs[i].expCode));
            check("vec_csr_num", 32'(csr_num), 32'(vecs[i].num));
            check("vec_csr_wdata", csr_wdata, vecs[i].wdata);
            check("vec_pipe_rdata", pipe_rdata, vecs[i].expRdata);
            check("vec_pipe_stall", 32'(pipe_stall), 32'd0);
        end

        // A: host read of 0x300, pipeline idle, response held under back-pressure.
        tick();
        pipe_req = 1'b0; pipe_we = 1'b0; pipe_num = 12'h000; pipe_code = 2'b11; pipe_wdata = '0;
        host_resp_ready = 1'b0;
        hostDrive(1'b0, 12'h300, 32'h0);
        respQ.push_back(32'h0000_1800);
        #2;
        check("a_idle_ready", 32'(host_req_ready), 32'd1);
        tick();
        host_req_valid = 1'b0;
        #2;
        check("a_wait_ready", 32'(host_req_ready), 32'd0);
        check("a_wait_csr_we", 32'(csr_we), 32'd0);
        check("a_wait_csr_num", 32'(csr_num), 32'h000);
        tick();
        #2;
        check("a_acc_csr_num", 32'(csr_num), 32'h300);
        check("a_acc_csr_we", 32'(csr_we), 32'd0);
        check("a_acc_csr_code", 32'(csr_code), 32'd3);
        check("a_acc_pipe_rdata", pipe_rdata, 32'd0);
        check("a_acc_pipe_stall", 32'(pipe_stall), 32'd0);
        tick();
        #2;
        check("a_resp_valid", 32'(host_resp_valid), 32'd1);
        check("a_resp_data", host_resp_data, 32'h0000_1800);
        repeat (2) begin
            tick();
            #2;
            check("a_hold_valid", 32'(host_resp_valid), 32'd1);
            check("a_hold_data", host_resp_data, 32'h0000_1800);
        end
        host_resp_ready = 1'b1;
        tick();
        #2;
        check("a_done_valid", 32'(host_resp_valid), 32'd0);
        check("a_done_ready", 32'(host_req_ready), 32'd1);

        // B: host write returns the old value, then a read sees the new one.
        hostDrive(1'b1, 12'h340, 32'hDEAD_BEEF);
        respQ.push_back(32'h0);
        tick();
        host_req_valid = 1'b0;
        tick();
        #2;
        check("b_acc_csr_we", 32'(csr_we), 32'd1);
        check("b_acc_csr_code", 32'(csr_code), 32'd0);
        check("b_acc_csr_num", 32'(csr_num), 32'h340);
        check("b_acc_csr_wdata", csr_wdata, 32'hDEAD_BEEF);
        tick();
        #2;
        check("b_resp_valid", 32'(host_resp_valid), 32'd1);
        tick();
        hostTxn(1'b0, 12'h340, 32'h0, 32'hDEAD_BEEF, "b_read");

        // C: starvation; pipeline writes 0x305 every cycle.
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_num = 12'h305; pipe_code = 2'b00; pipe_wdata = '0;
        hostDrive(1'b0, 12'h300, 32'h0);
        respQ.push_back(32'h0000_1800);
        tick();
        host_req_valid = 1'b0;
        for (int c = 1; c <= int'(LIMIT) + 1; c++) begin
            pipe_wdata = 32'(c);
            #2;
            check("c_wait_stall", 32'(pipe_stall), 32'd0);
            check("c_wait_csr_num", 32'(csr_num), 32'h305);
            check("c_wait_csr_we", 32'(csr_we), 32'd1);
            tick();
        end
        pipe_wdata = 32'(LIMIT + 2);
        #2;
        check("c_acc_stall", 32'(pipe_stall), 32'd1);
        check("c_acc_csr_num", 32'(csr_num), 32'h300);
        check("c_acc_csr_we", 32'(csr_we), 32'd0);
        check("c_acc_pipe_rdata", pipe_rdata, 32'd0);
        tick();
        #2;
        check("c_retry_stall", 32'(pipe_stall), 32'd0);
        check("c_retry_csr_we", 32'(csr_we), 32'd1);
        check("c_retry_csr_num", 32'(csr_num), 32'h305);
        check("c_retry_pipe_rdata", pipe_rdata, 32'(LIMIT + 1));
        check("c_resp_valid", 32'(host_resp_valid), 32'd1);
        tick();
        pipe_we = 1'b0; pipe_code = 2'b11;
        #2;
        check("c_retry_landed", pipe_rdata, 32'(LIMIT + 2));

        // D: pipeline write and host request in the same cycle.
        tick();
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_num = 12'h305; pipe_code = 2'b00;
        pipe_wdata = 32'h0000_5A5A;
        hostDrive(1'b0, 12'h305, 32'h0);
        respQ.push_back(32'h0000_5A5A);
        #2;
        check("d_c0_stall", 32'(pipe_stall), 32'd0);
        check("d_c0_csr_we", 32'(csr_we), 32'd1);
        check("d_c0_csr_num", 32'(csr_num), 32'h305);
        check("d_c0_ready", 32'(host_req_ready), 32'd1);
        tick();
        host_req_valid = 1'b0; pipe_req = 1'b0; pipe_we = 1'b0;
        #2;
        check("d_wait_ready", 32'(host_req_ready), 32'd0);
        check("d_wait_csr_we", 32'(csr_we), 32'd0);
        tick();
        #2;
        check("d_acc_csr_num", 32'(csr_num), 32'h305);
        check("d_acc_csr_code", 32'(csr_code), 32'd3);
        tick();
        #2;
        check("d_resp_valid", 32'(host_resp_valid), 32'd1);
        tick();

        // E: response back-pressure while the pipeline keeps accessing.
        host_resp_ready = 1'b0;
        hostDrive(1'b0, 12'h340, 32'h0);
        respQ.push_back(32'hDEAD_BEEF);
        tick();
        host_req_valid = 1'b0;
        waitResp(LIMIT + 4, "e_first");
        hostDrive(1'b0, 12'h300, 32'h0);
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_num = 12'h340; pipe_code = 2'b00;
        for (int k = 0; k < 5; k++) begin
            pipe_wdata = 32'h1111_0000 + 32'(k);
            #2;
            check("e_hold_data", host_resp_data, 32'hDEAD_BEEF);
            check("e_hold_valid", 32'(host_resp_valid), 32'd1);
            check("e_no_stall", 32'(pipe_stall), 32'd0);
            check("e_pipe_we", 32'(csr_we), 32'd1);
            check("e_no_accept", 32'(host_req_ready), 32'd0);
            check("e_pipe_rdata", pipe_rdata,
                  (k == 0) ? 32'hDEAD_BEEF : 32'h1111_0000 + 32'(k - 1));
            tick();
        end
        host_resp_ready = 1'b1;
        pipe_req = 1'b0; pipe_we = 1'b0;
        respQ.push_back(32'h0000_1800);
        tick();
        #2;
        check("e_ready_back", 32'(host_req_ready), 32'd1);
        tick();
        host_req_valid = 1'b0;
        waitResp(LIMIT + 4, "e_second");
        tick();

        // F: reset while a write waits; it must never reach the CSR.
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_num = 12'h000; pipe_code = 2'b11;
        hostDrive(1'b1, 12'h300, 32'hBAD0_BAD0);
        tick();
        host_req_valid = 1'b0;
        #2;
        check("f_wait_ready", 32'(host_req_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0; pipe_req = 1'b0;
        #2;
        check("f_rst_ready", 32'(host_req_ready), 32'd1);
        check("f_rst_valid", 32'(host_resp_valid), 32'd0);
        check("f_rst_csr_we", 32'(csr_we), 32'd0);
        repeat (3) begin
            tick();
            #2;
            check("f_idle_valid", 32'(host_resp_valid), 32'd0);
            check("f_idle_csr_we", 32'(csr_we), 32'd0);
        end
        tick();
        hostTxn(1'b0, 12'h300, 32'h0, 32'h0000_1800, "f_read");

`ifdef CSR_ARB_STALL_COUNT_EN
        check("stall_count", stall_count, 32'd1);
`endif
        tick();
        check("queue_empty", 32'(respQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
